// File: rtl/ex_mem_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_pipe_stage
// Description : Parametrised EX->MEM pipeline register for the 32-bit MIPS
//               core. DEPTH register slices with a per-slice valid bit,
//               stall (hold), bubble insertion (FlushE) and full kill (KillM).
//               Optional stall/bubble performance counters are built when the
//               macro EXMEM_PERF_CNT_EN is defined; otherwise the counter
//               outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_pipe_stage #(
    parameter int ALUOUT_WIDTH    = 32,
    parameter int WRITEDATA_WIDTH = 32,
    parameter int WRITEREG_WIDTH  = 5,
    parameter int DEPTH           = 1,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       StallM,
    input  logic                       FlushE,
    input  logic                       KillM,
    input  logic                       ValidE,
    input  logic                       RegWriteE,
    input  logic                       MemtoRegE,
    input  logic                       MemWriteE,
    input  logic [ALUOUT_WIDTH-1:0]    ALUOutE,
    input  logic [WRITEDATA_WIDTH-1:0] WriteDataE,
    input  logic [WRITEREG_WIDTH-1:0]  WriteRegE,
    output logic                       ValidM,
    output logic                       RegWriteM,
    output logic                       MemtoRegM,
    output logic                       MemWriteM,
    output logic [ALUOUT_WIDTH-1:0]    ALUOutM,
    output logic [WRITEDATA_WIDTH-1:0] WriteDataM,
    output logic [WRITEREG_WIDTH-1:0]  WriteRegM,
    output logic                       PipeEmptyM,
    output logic [CNT_WIDTH-1:0]       StallCntM,
    output logic [CNT_WIDTH-1:0]       BubbleCntM
);

    // Reject unsupported slice depths at elaboration time
    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
        $error("ex_mem_pipe_stage: DEPTH must be in 1..4");
    end

    // Slice storage; index 0 is fed from EX, index DEPTH-1 drives MEM
    logic [DEPTH-1:0]           r_valid;
    logic [DEPTH-1:0]           r_regwrite;
    logic [DEPTH-1:0]           r_memtoreg;
    logic [DEPTH-1:0]           r_memwrite;
    logic [ALUOUT_WIDTH-1:0]    r_aluout    [DEPTH];
    logic [WRITEDATA_WIDTH-1:0] r_writedata [DEPTH];
    logic [WRITEREG_WIDTH-1:0]  r_writereg  [DEPTH];

    // Slice 0 takes a real instruction only when EX has one and no flush
    logic w_load;
    assign w_load = ValidE & ~FlushE;

    // Slice shift register: reset/kill clear everything, stall holds,
    // otherwise shift with slice 0 taking either the EX bundle or a bubble
    always_ff @(posedge CLK) begin
        if (RST || KillM) begin
            r_valid    <= '0;
            r_regwrite <= '0;
            r_memtoreg <= '0;
            r_memwrite <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_aluout[k]    <= '0;
                r_writedata[k] <= '0;
                r_writereg[k]  <= '0;
            end
        end else if (!StallM) begin
            r_valid[0]     <= w_load;
            r_regwrite[0]  <= w_load & RegWriteE;
            r_memtoreg[0]  <= w_load & MemtoRegE;
            r_memwrite[0]  <= w_load & MemWriteE;
            r_aluout[0]    <= w_load ? ALUOutE    : '0;
            r_writedata[0] <= w_load ? WriteDataE : '0;
            r_writereg[0]  <= w_load ? WriteRegE  : '0;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k]     <= r_valid[k-1];
                r_regwrite[k]  <= r_regwrite[k-1];
                r_memtoreg[k]  <= r_memtoreg[k-1];
                r_memwrite[k]  <= r_memwrite[k-1];
                r_aluout[k]    <= r_aluout[k-1];
                r_writedata[k] <= r_writedata[k-1];
                r_writereg[k]  <= r_writereg[k-1];
            end
        end
    end

    assign ValidM     = r_valid[DEPTH-1];
    assign RegWriteM  = r_regwrite[DEPTH-1];
    assign MemtoRegM  = r_memtoreg[DEPTH-1];
    assign MemWriteM  = r_memwrite[DEPTH-1];
    assign ALUOutM    = r_aluout[DEPTH-1];
    assign WriteDataM = r_writedata[DEPTH-1];
    assign WriteRegM  = r_writereg[DEPTH-1];
    assign PipeEmptyM = ~|r_valid;

`ifdef EXMEM_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_bubble_cnt;

    // Saturating stall/bubble counters; only reset clears them, kill does not
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (!KillM) begin
            if (StallM) begin
                if (r_stall_cnt != C_CNT_MAX) begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
            end else if (!w_load) begin
                if (r_bubble_cnt != C_CNT_MAX) begin
                    r_bubble_cnt <= r_bubble_cnt + 1'b1;
                end
            end
        end
    end

    assign StallCntM  = r_stall_cnt;
    assign BubbleCntM = r_bubble_cnt;
`else
    assign StallCntM  = '0;
    assign BubbleCntM = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_pipe_stage
// Description : Self-checking bench for ex_mem_pipe_stage (DEPTH=3,
//               CNT_WIDTH=4). Instructions entering slice 0 are queued with
//               the advance count at which they must reach MEM; each cycle
//               the MEM outputs are compared with the queued expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_pipe_stage;

    localparam int DEPTH     = 3;
    localparam int CNT_WIDTH = 4;
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        StallM = 1'b0, FlushE = 1'b0, KillM = 1'b0, ValidE = 1'b0;
    logic        RegWriteE = 1'b0, MemtoRegE = 1'b0, MemWriteE = 1'b0;
    logic [31:0] ALUOutE = '0, WriteDataE = '0;
    logic [4:0]  WriteRegE = '0;
    logic        ValidM, RegWriteM, MemtoRegM, MemWriteM, PipeEmptyM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;
    logic [CNT_WIDTH-1:0] StallCntM, BubbleCntM;

    ex_mem_pipe_stage #(
        .ALUOUT_WIDTH   (32),
        .WRITEDATA_WIDTH(32),
        .WRITEREG_WIDTH (5),
        .DEPTH          (DEPTH),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .StallM    (StallM),
        .FlushE    (FlushE),
        .KillM     (KillM),
        .ValidE    (ValidE),
        .RegWriteE (RegWriteE),
        .MemtoRegE (MemtoRegE),
        .MemWriteE (MemWriteE),
        .ALUOutE   (ALUOutE),
        .WriteDataE(WriteDataE),
        .WriteRegE (WriteRegE),
        .ValidM    (ValidM),
        .RegWriteM (RegWriteM),
        .MemtoRegM (MemtoRegM),
        .MemWriteM (MemWriteM),
        .ALUOutM   (ALUOutM),
        .WriteDataM(WriteDataM),
        .WriteRegM (WriteRegM),
        .PipeEmptyM(PipeEmptyM),
        .StallCntM (StallCntM),
        .BubbleCntM(BubbleCntM)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        v, rw, mr, mw;
        logic [31:0] alu, wd;
        logic [4:0]  wr;
        int          due;
    } ent_t;

    ent_t q[$];
    ent_t exp_m;
    ent_t c_bubble;
    int   adv = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [CNT_WIDTH-1:0] mdl_stall = '0, mdl_bubble = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Advance one clock, update the expectation model, then compare outputs
    task automatic tick();
        ent_t e;
        @(posedge CLK);
        if (RST || KillM) begin
            q.delete();
            exp_m = c_bubble;
            if (RST) begin
                mdl_stall  = '0;
                mdl_bubble = '0;
            end
        end else if (StallM) begin
            if (mdl_stall != C_CNT_MAX) mdl_stall = mdl_stall + 1'b1;
        end else begin
            adv++;
            if (ValidE && !FlushE) begin
                e.v = 1'b1; e.rw = RegWriteE; e.mr = MemtoRegE; e.mw = MemWriteE;
                e.alu = ALUOutE; e.wd = WriteDataE; e.wr = WriteRegE;
                e.due = adv + DEPTH - 1;
                q.push_back(e);
            end else if (mdl_bubble != C_CNT_MAX) begin
                mdl_bubble = mdl_bubble + 1'b1;
            end
            if (q.size() > 0 && q[0].due == adv) exp_m = q.pop_front();
            else exp_m = c_bubble;
        end
        #1;
        check("ValidM",     {63'd0, ValidM},    {63'd0, exp_m.v});
        check("RegWriteM",  {63'd0, RegWriteM}, {63'd0, exp_m.rw});
        check("MemtoRegM",  {63'd0, MemtoRegM}, {63'd0, exp_m.mr});
        check("MemWriteM",  {63'd0, MemWriteM}, {63'd0, exp_m.mw});
        check("ALUOutM",    {32'd0, ALUOutM},   {32'd0, exp_m.alu});
        check("WriteDataM", {32'd0, WriteDataM},{32'd0, exp_m.wd});
        check("WriteRegM",  {59'd0, WriteRegM}, {59'd0, exp_m.wr});
        check("PipeEmptyM", {63'd0, PipeEmptyM},
              {63'd0, (q.size() == 0 && !exp_m.v)});
`ifdef EXMEM_PERF_CNT_EN
        check("StallCntM",  64'(StallCntM),  64'(mdl_stall));
        check("BubbleCntM", 64'(BubbleCntM), 64'(mdl_bubble));
`else
        check("StallCntM",  64'(StallCntM),  64'd0);
        check("BubbleCntM", 64'(BubbleCntM), 64'd0);
`endif
    endtask

    task automatic put(input logic v, input logic rw, input logic mr, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
        ValidE = v; RegWriteE = rw; MemtoRegE = mr; MemWriteE = mw;
        ALUOutE = alu; WriteDataE = wd; WriteRegE = wr;
    endtask

    task automatic idle(input int n);
        put(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        c_bubble = '{v: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, alu: 32'd0, wd: 32'd0, wr: 5'd0, due: 0};
        exp_m = c_bubble;

        // Reset held two cycles
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;

        // Single instruction, plus WriteReg=0 with RegWrite=1 passing through
        put(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5); tick();
        put(1'b1, 1'b1, 1'b0, 1'b0, 32'h55AA, 32'h1, 5'd0); tick();
        idle(4);

        // Three back-to-back instructions
        put(1'b1, 1'b1, 1'b1, 1'b0, 32'hA0A0_0001, 32'h11, 5'd1); tick();
        put(1'b1, 1'b0, 1'b0, 1'b1, 32'hB0B0_0002, 32'h22, 5'd2); tick();
        put(1'b1, 1'b1, 1'b0, 1'b0, 32'hC0C0_0003, 32'h33, 5'd3); tick();
        idle(4);

        // Stall two cycles mid-stream, FlushE asserted during the stall
        put(1'b1, 1'b1, 1'b0, 1'b0, 32'h1111, 32'h1, 5'd7); tick();
        put(1'b1, 1'b0, 1'b1, 1'b0, 32'h2222, 32'h2, 5'd8); tick();
        put(1'b1, 1'b1, 1'b0, 1'b1, 32'h3333, 32'h3, 5'd9); tick();
        put(1'b1, 1'b0, 1'b0, 1'b1, 32'h4444, 32'h4, 5'd10);
        StallM = 1'b1; FlushE = 1'b1; tick(); tick();
        StallM = 1'b0; FlushE = 1'b0; tick();
        idle(4);

        // Flush a store: it must surface as a bubble
        put(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hCAFE, 5'd4);
        FlushE = 1'b1; tick(); FlushE = 1'b0;
        idle(4);

        // Full pipe, KillM together with StallM
        put(1'b1, 1'b1, 1'b0, 0, 32'h10, 32'h0, 5'd11); tick();
        put(1'b1, 1'b1, 1'b1, 0, 32'h20, 32'h0, 5'd12); tick();
        put(1'b1, 1'b0, 1'b0, 1, 32'h30, 32'h5, 5'd13); tick();
        KillM = 1'b1; StallM = 1'b1; tick();
        KillM = 1'b0; StallM = 1'b0;
        idle(2);

        // Reset mid-stream
        put(1'b1, 1'b1, 1'b0, 0, 32'h77, 32'h0, 5'd14); tick();
        put(1'b1, 1'b1, 1'b0, 0, 32'h88, 32'h0, 5'd15); tick();
        RST = 1'b1; tick(); RST = 1'b0;
        idle(2);

        // Long stall with a loaded pipe: stall counter saturates
        put(1'b1, 1'b1, 1'b0, 0, 32'h99, 32'h9, 5'd16); tick();
        StallM = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        StallM = 1'b0;

        // Three flushed advances
        put(1'b1, 1'b0, 1'b0, 1'b1, 32'hF1, 32'hF2, 5'd17);
        FlushE = 1'b1; tick(); tick(); tick(); FlushE = 1'b0;
        idle(3);

        // Randomised traffic
        for (int i = 0; i < 60; i++) begin
            put(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom, $urandom, 5'($urandom));
            StallM = ($urandom_range(0, 4) == 0);
            FlushE = ($urandom_range(0, 5) == 0);
            KillM  = ($urandom_range(0, 15) == 0);
            tick();
        end
        StallM = 1'b0; FlushE = 1'b0; KillM = 1'b0;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
